// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with shared prescaler and phase
// counter, edge/center-aligned modes and period-boundary shadow registers.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           global enable; 0 holds counters at 0 and drives outputs low
//   dvsr         prescaler divisor; one phase step every dvsr+1 clocks
//   mode         0 = edge-aligned, 1 = center-aligned (captured on load)
//   duty         packed duty words, channel i = duty[i*(R+1) +: R+1]
//   load         one-cycle strobe capturing duty and mode
//   pwm_out      registered PWM outputs, one per channel
//   period_start one-clock pulse when the phase counter re-enters 0
//
// Edge mode: period 2^R ticks. Center mode: period 2*(2^R-1) ticks.
// Center mode needs R >= 2 so the down-count can reach the d == 1 boundary.

module pwm_multi #(
    parameter int CH = 4,
    parameter int R  = 10,
    parameter int W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [W-1:0]        dvsr,
    input  logic                mode,
    input  logic [CH*(R+1)-1:0] duty,
    input  logic                load,
    output logic [CH-1:0]       pwm_out,
    output logic                period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [R-1:0] PH_MAX  = {R{1'b1}};
    localparam logic [R-1:0] PH_ONE  = {{(R-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] PS_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam int           DW      = CH * (R + 1);

    // Prescaler and phase counter
    logic [W-1:0]  presc_q, presc_d;
    logic [R-1:0]  phase_q, phase_d;
    dir_e          dir_q, dir_d;

    // Shadow registers: pending (written by load), active (used by compare)
    logic [DW-1:0] duty_pend_q, duty_pend_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic          mode_pend_q, mode_pend_d;
    logic          mode_act_q, mode_act_d;
    logic          pend_q, pend_d;

    // Registered outputs
    logic [CH-1:0] pwm_q, pwm_d;
    logic          pstart_q, pstart_d;

    logic          tick;
    logic          boundary;

    // Prescaler. Using >= lets a lowered divisor take effect on the next
    // clock instead of running the counter all the way around 2^W.
    always_comb begin
        tick    = (presc_q == '0);
        presc_d = presc_q;
        if (!en) begin
            presc_d = '0;
        end else if (presc_q >= dvsr) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_ONE;
        end
    end

    // Period boundary: the tick whose next phase value is 0.
    always_comb begin
        boundary = 1'b0;
        if (en && tick) begin
            if (mode_act_q) begin
                boundary = (dir_q == DIR_DOWN) && (phase_q == PH_ONE);
            end else begin
                boundary = (phase_q == PH_MAX);
            end
        end
    end

    // Phase counter and direction. Restarting at 0/up on every boundary also
    // gives a clean start when the active mode changes at that boundary.
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        if (!en) begin
            phase_d = '0;
            dir_d   = DIR_UP;
        end else if (tick) begin
            if (boundary) begin
                phase_d = '0;
                dir_d   = DIR_UP;
            end else if (!mode_act_q) begin
                phase_d = phase_q + PH_ONE;
            end else if (dir_q == DIR_UP) begin
                if (phase_q == PH_MAX) begin
                    // Turn around without repeating the top value.
                    phase_d = phase_q - PH_ONE;
                    dir_d   = DIR_DOWN;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end else begin
                phase_d = phase_q - PH_ONE;
            end
        end
    end

    // Shadow registers. While disabled there is no period to protect, so
    // settings go straight to active and the first enabled period uses them.
    always_comb begin
        duty_pend_d = duty_pend_q;
        mode_pend_d = mode_pend_q;
        duty_act_d  = duty_act_q;
        mode_act_d  = mode_act_q;
        pend_d      = pend_q;

        if (load) begin
            duty_pend_d = duty;
            mode_pend_d = mode;
        end

        if (!en || boundary) begin
            if (load) begin
                duty_act_d = duty;
                mode_act_d = mode;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                duty_act_d = duty_pend_q;
                mode_act_d = mode_pend_q;
                pend_d     = 1'b0;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // Per-channel compare against the current phase; registered, so the
    // output trails the phase counter by one clock.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CH; i++) begin
            pwm_d[i] = en && ({1'b0, phase_q} < duty_act_q[i*(R+1) +: R+1]);
        end
        pstart_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            phase_q     <= '0;
            dir_q       <= DIR_UP;
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            mode_pend_q <= 1'b0;
            mode_act_q  <= 1'b0;
            pend_q      <= 1'b0;
            pwm_q       <= '0;
            pstart_q    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            mode_pend_q <= mode_pend_d;
            mode_act_q  <= mode_act_d;
            pend_q      <= pend_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed, table-driven checks of pwm_multi (CH=2, R=4)
// plus hand sequences for shadow loads, divisor change, reset and enable.

module tb_pwm_multi;

    localparam int CH = 2;
    localparam int R  = 4;
    localparam int W  = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic [W-1:0]        dvsr;
    logic                mode;
    logic [CH*(R+1)-1:0] duty;
    logic                load;
    logic [CH-1:0]       pwm_out;
    logic                period_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .R(R), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .dvsr         (dvsr),
        .mode         (mode),
        .duty         (duty),
        .load         (load),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    typedef struct {
        int dvsr;
        int mode;
        int d0;
        int d1;
        int period;
        int hi0;
        int hi1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int d0, input int d1);
        duty[0 +: R+1]     = (R+1)'(d0);
        duty[R+1 +: R+1]   = (R+1)'(d1);
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        step;
        step;
        reset = 1'b0;
        step;
    endtask

    // Load while disabled so settings become active immediately.
    task automatic preload(input int dv, input int m, input int d0, input int d1);
        en   = 1'b0;
        dvsr = W'(dv);
        mode = m[0];
        set_duty(d0, d1);
        load = 1'b1;
        step;
        load = 1'b0;
    endtask

    task automatic wait_ps(input string name, input int limit, output int n);
        n = 0;
        while (period_start !== 1'b1 && n < limit) begin
            step;
            n++;
        end
        check(name, int'(period_start), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int c0, c1, cp;
        int cnt[5];
        int psc[5];
        logic [15:0] pat, psp;

        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        mode  = 1'b0;
        dvsr  = '0;
        duty  = '0;

        vecs[0] = '{0, 0, 4, 16, 16, 4, 16};
        vecs[1] = '{2, 0, 4, 0, 48, 12, 0};
        vecs[2] = '{0, 1, 4, 0, 30, 7, 0};
        vecs[3] = '{0, 1, 16, 1, 30, 30, 1};
        vecs[4] = '{1, 1, 15, 3, 60, 58, 10};
        vecs[5] = '{0, 0, 0, 15, 16, 0, 15};
        vecs[6] = '{3, 0, 31, 1, 64, 64, 4};

        step;
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset period_start", int'(period_start), 0);

        // Steady-state duty and period counts over two full periods.
        foreach (vecs[v]) begin
            apply_reset;
            preload(vecs[v].dvsr, vecs[v].mode, vecs[v].d0, vecs[v].d1);
            en = 1'b1;
            repeat (vecs[v].period + 3) step;
            c0 = 0;
            c1 = 0;
            cp = 0;
            repeat (2 * vecs[v].period) begin
                step;
                c0 += pwm_out[0] ? 1 : 0;
                c1 += pwm_out[1] ? 1 : 0;
                cp += period_start ? 1 : 0;
            end
            check($sformatf("vec%0d hi0", v), c0, 2 * vecs[v].hi0);
            check($sformatf("vec%0d hi1", v), c1, 2 * vecs[v].hi1);
            check($sformatf("vec%0d pstart", v), cp, 2);
        end

        // Shadow updates: mid-period load, last-write-wins, coincident load.
        apply_reset;
        preload(0, 0, 4, 0);
        en = 1'b1;
        wait_ps("shadow sync", 100, n);
        for (int w = 0; w < 5; w++) begin
            cnt[w] = 0;
            psc[w] = 0;
        end
        for (int s = 0; s < 80; s++) begin
            load = 1'b0;
            case (s)
                6:  begin set_duty(8, 0);  load = 1'b1; end
                20: begin set_duty(12, 0); load = 1'b1; end
                25: begin set_duty(2, 0);  load = 1'b1; end
                47: begin set_duty(6, 0);  load = 1'b1; end
                default: ;
            endcase
            step;
            if (pwm_out[0]) cnt[s / 16]++;
            if (period_start && ((s + 1) % 16 == 0)) psc[s / 16]++;
        end
        load = 1'b0;
        check("shadow p0 old duty", cnt[0], 4);
        check("shadow p1 new duty", cnt[1], 8);
        check("shadow p2 last wins", cnt[2], 2);
        check("shadow p3 coincident", cnt[3], 6);
        check("shadow p4 stable", cnt[4], 6);
        for (int w = 0; w < 5; w++) begin
            check($sformatf("shadow pstart w%0d", w), psc[w], 1);
        end

        // Lowering the divisor below the running prescaler value.
        apply_reset;
        preload(100, 0, 4, 0);
        en = 1'b1;
        wait_ps("dvsr sync", 2000, n);
        repeat (49) step;
        dvsr = W'(5);
        wait_ps("dvsr first pstart", 300, n);
        check("dvsr clocks to pstart", n, 92);
        step;
        wait_ps("dvsr second pstart", 300, n);
        check("dvsr period", n + 1, 96);

        // Asynchronous reset while outputs are high.
        apply_reset;
        preload(0, 0, 16, 8);
        en = 1'b1;
        wait_ps("reset sync", 100, n);
        check("reset pre pwm0", int'(pwm_out[0]), 1);
        reset = 1'b1;
        #1;
        check("async reset pwm_out", int'(pwm_out), 0);
        check("async reset pstart", int'(period_start), 0);
        step;
        reset = 1'b0;
        c0 = 0;
        repeat (40) begin
            step;
            c0 += (pwm_out != '0) ? 1 : 0;
        end
        check("post reset idle", c0, 0);

        // Enable sequencing: restart from phase 0, no pulse at enable.
        en = 1'b0;
        step;
        preload(0, 0, 4, 0);
        en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            step;
            pat[t] = pwm_out[0];
            psp[t] = period_start;
        end
        check("enable pattern", int'(pat), 16'h000F);
        check("enable pstart", int'(psp), 16'h8000);
        step;
        check("pre disable pwm0", int'(pwm_out[0]), 1);
        en = 1'b0;
        step;
        check("disable pwm_out", int'(pwm_out), 0);
        check("disable pstart", int'(period_start), 0);
        en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            step;
            pat[t] = pwm_out[0];
            psp[t] = period_start;
        end
        check("reenable pattern", int'(pat), 16'h000F);
        check("reenable pstart", int'(psp), 16'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
